// File: rtl/mem_region_decoder_if.sv
// Request/response bundle between a bus master and mem_region_decoder.
// The master drives the request side; the decoder drives chip selects and status.
interface mem_region_decoder_if #(
    parameter int ADDR_W = 32,
    parameter int SEL_W  = 2,
    parameter int WAIT_W = 4
);
    localparam int NUM_CS = 2 ** SEL_W;

    logic                     en;
    logic [ADDR_W-1:0]        addr;
    logic [NUM_CS-1:0]        region_en;
    logic [NUM_CS*WAIT_W-1:0] ws_cfg;
    logic [NUM_CS-1:0]        cs;
    logic                     ready;
    logic                     err;
    logic                     busy;

    modport master (
        output en, addr, region_en, ws_cfg,
        input  cs, ready, err, busy
    );

    modport slave (
        input  en, addr, region_en, ws_cfg,
        output cs, ready, err, busy
    );
endinterface

// File: rtl/mem_region_decoder.sv
// Registered region decoder: top SEL_W address bits pick a one-hot chip select held for
// ws+2 cycles, or an err pulse for disabled regions. Define MEMDEC_B2B_EN to accept in DONE.
module mem_region_decoder #(
    parameter int ADDR_W = 32,
    parameter int SEL_W  = 2,
    parameter int WAIT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_region_decoder_if.slave  bus
);
    localparam int NUM_CS = 2 ** SEL_W;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t                         state_q, state_d;
    logic [NUM_CS-1:0]              cs_q, cs_d;
    logic                           ready_q, ready_d;
    logic                           err_q, err_d;
    logic [WAIT_W-1:0]              cnt_q, cnt_d;

    logic [SEL_W-1:0]               idx;
    logic [NUM_CS-1:0][WAIT_W-1:0]  ws_arr;
    logic [WAIT_W-1:0]              ws;
    logic                           hit;
    logic                           accept;
    logic                           unused_addr;

    assign idx         = bus.addr[ADDR_W-1 -: SEL_W];
    assign unused_addr = ^bus.addr[ADDR_W-SEL_W-1:0];

    for (genvar i = 0; i < NUM_CS; i++) begin : g_ws
        assign ws_arr[i] = bus.ws_cfg[i*WAIT_W +: WAIT_W];
    end

    assign ws  = ws_arr[idx];
    assign hit = bus.region_en[idx];

`ifdef MEMDEC_B2B_EN
    // DONE is a legal accept point, so cs can hand over without an idle cycle
    assign accept = bus.en && (state_q == IDLE || state_q == DONE);
`else
    assign accept = bus.en && (state_q == IDLE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cs_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = hit ? ACCESS : ERR;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                ACCESS:  if (cnt_q == '0) state_d = DONE;
                DONE:    state_d = IDLE;
                ERR:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next register values for the outputs; all outputs leave straight from flops
    always_comb begin
        cs_d    = '0;
        ready_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (accept) begin
            if (hit) begin
                cs_d  = {{(NUM_CS-1){1'b0}}, 1'b1} << idx;
                cnt_d = ws;
            end else begin
                err_d = 1'b1;
                cnt_d = '0;
            end
        end else begin
            unique case (state_q)
                ACCESS: begin
                    cs_d = cs_q;
                    if (cnt_q != '0) cnt_d = cnt_q - WAIT_W'(1);
                    else             ready_d = 1'b1;
                end
                default: cnt_d = '0;
            endcase
        end
    end

    assign bus.cs    = cs_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_mem_region_decoder.sv
// Randomized and directed bench for mem_region_decoder against an edge-numbered
// timeline model: each accepted request books the edges on which cs/ready/err appear.
module tb_mem_region_decoder;
    localparam int ADDR_W = 32;
    localparam int SEL_W  = 2;
    localparam int WAIT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem_region_decoder_if #(.ADDR_W(ADDR_W), .SEL_W(SEL_W), .WAIT_W(WAIT_W)) bus ();

    mem_region_decoder #(.ADDR_W(ADDR_W), .SEL_W(SEL_W), .WAIT_W(WAIT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Timeline model: e counts rising edges since reset; outputs after edge e follow
    // from the accept edge and wait count of the last accepted request.
    int e       = 0;
    int cs_from = -10;
    int cs_to   = -10;
    int rdy_e   = -10;
    int err_e   = -10;
    int free_at = 0;
    int cs_idx  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e = 0; cs_from = -10; cs_to = -10; rdy_e = -10; err_e = -10; free_at = 0;
        end else begin
            e++;
            if (e >= free_at && bus.en === 1'b1) begin
                int idx, ws;
                logic [15:0] sh;
                idx = int'(bus.addr[31:30]);
                sh  = bus.ws_cfg >> (idx * WAIT_W);
                ws  = int'(sh[3:0]);
                if (bus.region_en[idx]) begin
                    cs_idx  = idx;
                    cs_from = e;
                    cs_to   = e + ws + 1;
                    rdy_e   = e + ws + 1;
`ifdef MEMDEC_B2B_EN
                    free_at = e + ws + 2;
`else
                    free_at = e + ws + 3;
`endif
                end else begin
                    err_e   = e;
                    free_at = e + 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_cs;
        logic       exp_rdy, exp_err;
        exp_cs  = (e >= cs_from && e <= cs_to) ? 4'(1 << cs_idx) : 4'b0;
        exp_rdy = (e == rdy_e);
        exp_err = (e == err_e);
        chk("cs",      32'(bus.cs),    32'(exp_cs));
        chk("ready",   32'(bus.ready), 32'(exp_rdy));
        chk("err",     32'(bus.err),   32'(exp_err));
        chk("busy",    32'(bus.busy),  32'((exp_cs != 4'b0) || exp_err));
        chk("onehot0", 32'($onehot0(bus.cs)), 32'd1);
        chk("rdy_err_excl", 32'(bus.ready & bus.err), 32'd0);
    end

    // One-cycle en pulse, then observe until busy falls. len = first sample with busy low.
    task automatic run_access(input logic [31:0] a, input logic [15:0] wsc, input logic [3:0] ren,
                              input bit noise, output logic [3:0] seen, output int cs_n,
                              output int rdy_at, output int err_n, output int len);
        @(negedge clk);
        bus.addr = a; bus.ws_cfg = wsc; bus.region_en = ren; bus.en = 1'b1;
        seen = '0; cs_n = 0; rdy_at = -1; err_n = 0; len = 41;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.cs != 4'b0) begin cs_n++; seen |= bus.cs; end
            if (bus.ready) rdy_at = i;
            if (bus.err)   err_n++;
            if (noise && !bus.ready && bus.busy) begin
                bus.en = 1'($urandom); bus.addr = $urandom;
                bus.ws_cfg = 16'($urandom); bus.region_en = 4'($urandom);
            end else begin
                bus.en = 1'b0;
            end
            if (i > 1 && !bus.busy) begin len = i; break; end
        end
    endtask

    initial begin
        logic [3:0] seen, prev_cs;
        logic [3:0] seq [9];
        int cs_n, rdy_at, err_n, len, zeros;

        bus.en = 1'b0; bus.addr = '0; bus.region_en = 4'hF; bus.ws_cfg = '0;
        repeat (2) @(negedge clk);
        chk("reset_cs",   32'(bus.cs),   32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_access(32'h8000_0000, 16'h0000, 4'hF, 1'b0, seen, cs_n, rdy_at, err_n, len);
        chk("zw_cs", 32'(seen), 32'h4); chk("zw_n", cs_n, 2); chk("zw_rdy", rdy_at, 2); chk("zw_len", len, 3);

        run_access(32'hC000_0010, 16'h5000, 4'hF, 1'b1, seen, cs_n, rdy_at, err_n, len);
        chk("ws5_cs", 32'(seen), 32'h8); chk("ws5_n", cs_n, 7); chk("ws5_rdy", rdy_at, 7); chk("ws5_len", len, 8);

        run_access(32'h4000_0000, 16'h0000, 4'b1101, 1'b0, seen, cs_n, rdy_at, err_n, len);
        chk("dis_cs", cs_n, 0); chk("dis_err", err_n, 1); chk("dis_rdy", rdy_at, -1); chk("dis_len", len, 2);

        run_access(32'h8000_0000, 16'h0F00, 4'hF, 1'b0, seen, cs_n, rdy_at, err_n, len);
        chk("max_n", cs_n, 17); chk("max_rdy", rdy_at, 17);

        // reset mid-access: region 0, ws=10, reset three cycles after accept
        @(negedge clk);
        bus.addr = 32'h0; bus.ws_cfg = 16'h000A; bus.en = 1'b1;
        @(posedge clk); @(negedge clk); bus.en = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_cs",    32'(bus.cs),    32'd0);
        chk("arst_busy",  32'(bus.busy),  32'd0);
        chk("arst_ready", 32'(bus.ready), 32'd0);
        @(negedge clk); rst = 1'b0;
        run_access(32'h8000_0000, 16'h0000, 4'hF, 1'b0, seen, cs_n, rdy_at, err_n, len);
        chk("post_cs", 32'(seen), 32'h4); chk("post_n", cs_n, 2); chk("post_rdy", rdy_at, 2);

        // back-to-back with en held: region 1 then region 2, ws=1 each
        @(negedge clk);
        bus.addr = 32'h4000_0000; bus.ws_cfg = 16'h0110; bus.region_en = 4'hF; bus.en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            seq[i] = bus.cs;
            if (i == 0) bus.addr = 32'h8000_0000;
            if (bus.cs == 4'b0100) bus.en = 1'b0;
        end
        zeros = 0; prev_cs = seq[0];
        for (int i = 1; i < 9; i++) begin
            if (prev_cs == 4'b0010 && seq[i] == 4'b0) zeros++;
            if (seq[i] != 4'b0) prev_cs = seq[i];
        end
        chk("b2b_first", 32'(seq[2]), 32'h2);
`ifdef MEMDEC_B2B_EN
        chk("b2b_handover", 32'(seq[3]), 32'h4);
        chk("b2b_gap", zeros, 0);
`else
        chk("b2b_handover", 32'(seq[4]), 32'h4);
        chk("b2b_gap", zeros, 1);
`endif

        // random phase with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.en = ($urandom_range(0, 2) != 0);
            bus.addr = $urandom;
            bus.region_en = 4'($urandom);
            bus.ws_cfg = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'($urandom) & 16'h3333);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk); rst = 1'b0;
            end
        end
        bus.en = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_region_decoder.md
# mem_region_decoder

Parametrised, registered memory-region decoder with per-region wait states and a request/ready handshake. It sits between the bus master and the memory/peripheral chip selects: the top `SEL_W` address bits pick one of `2**SEL_W` regions. It then holds that region's chip select one-hot for a programmable number of wait cycles and signals completion. Requests to disabled regions are rejected with an error pulse instead of a chip select.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `SEL_W`, 2: number of top address bits decoded. `NUM_CS = 2**SEL_W` regions.
- `WAIT_W`, 4: width of each region's wait-state count.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: request valid.
- `addr` input `ADDR_W`: request address. Region index is `idx = addr[ADDR_W-1 -: SEL_W]`.
- `region_en` input `NUM_CS`: per-region enable mask.
- `ws_cfg` input `NUM_CS*WAIT_W`: packed wait counts. Region i uses `ws_cfg[i*WAIT_W +: WAIT_W]`.
- `cs` output `NUM_CS`: registered one-hot chip selects.
- `ready` output 1: one-cycle access-complete pulse.
- `err` output 1: one-cycle pulse for a request to a disabled region.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- IDLE with `en=1` at a rising edge:
  - The decoder latches `idx` and that region's wait count `ws`.
  - If `region_en[idx]=1`, it goes to ACCESS with `cs[idx]=1` and `cnt=ws`.
  - Otherwise it goes to ERR with `err=1` and `cs=0`.
- IDLE with `en=0`: the decoder stays in IDLE.
- ACCESS:
  - When `cnt!=0`, `cnt` decrements each edge.
  - When `cnt==0`, the next edge moves to DONE and sets `ready=1`. `cs` stays asserted.
- DONE: the next edge returns to IDLE and clears `cs` and `ready`, except as modified by `MEMDEC_B2B_EN`.
- ERR: the next edge returns to IDLE and clears `err`.
- Once a request is accepted, `addr`, `en`, `ws_cfg` and `region_en` are ignored until the decoder is back in IDLE. An accepted access always completes.
- `cs` is zero or one-hot at every cycle. It is never multi-hot and never glitches, since it is driven straight from a register.
- `ready` and `err` are never high in the same cycle.

## Timing
- Reset values: `cs=0`, `ready=0`, `err=0`, `busy=0`, state IDLE, `cnt=0`.
- `rst` takes effect immediately, including mid-access: `cs` drops without waiting for a clock. The first request is sampled at the first rising edge after `rst` falls.
- Let the accept edge be k:
  - `cs[idx]` is high from after edge k until after edge k+ws+2, i.e. for ws+2 cycles.
  - `ready` is high for exactly one cycle, after edge k+ws+1.
  - `busy` is high over the same cycles as `cs`.
- Rejected request accepted at edge k: `err` is high for one cycle after edge k. The decoder is back in IDLE after edge k+1.
- Back-to-back requests without the macro: the next acceptance is possible at edge k+ws+3 at the earliest. This leaves one idle cycle with `cs=0` between accesses.
- `ws` equal to the maximum value `2**WAIT_W-1` is legal; `cs` is then held for `2**WAIT_W+1` cycles.

## Configuration
- Macro `MEMDEC_B2B_EN`.
- Defined: in DONE, if `en=1` at the edge, the new request is decoded and accepted directly, as if from IDLE. There is no idle cycle.
  - Same region: `cs` stays continuously high.
  - Different region: `cs` switches one-hot in a single edge, with no overlap.
  - Disabled region: the decoder goes to ERR with `cs=0`.
- Undefined: `en` in DONE is ignored and the decoder always returns to IDLE for one cycle.

## Test plan
- Reset: assert `rst` asynchronously between edges → `cs=0`, `ready=0`, `err=0`, `busy=0` before the next edge. Then release.
- Zero-wait access: `ws_cfg` all 0, `region_en=4'b1111`, `addr=32'h8000_0000`, `en` pulsed for one cycle → `cs=4'b0100` for 2 cycles, with `ready` high in the second of those cycles.
- Wait states: region 3 `ws=5`, `addr=32'hC000_0010` → `cs=4'b1000` for 7 cycles and `ready` after accept edge +6. Changing `addr` and `en` during the access has no effect.
- Disabled region: `region_en=4'b1101`, `addr=32'h4000_0000` → `err` for 1 cycle, `cs` stays 0, `ready` stays 0, back in IDLE after 2 edges.
- Reset mid-access: region 0 `ws=10`, assert `rst` 3 cycles after accept → `cs` clears immediately. A fresh request after release behaves as in the zero-wait test.
- Back-to-back, with `en` held high for region 1 then region 2 (`ws=1`):
  - With `MEMDEC_B2B_EN`: `cs` goes from `4'b0010` to `4'b0100` with no zero cycle.
  - Without `MEMDEC_B2B_EN`: exactly one `cs=0` cycle between the two accesses.
